// File: rtl/ro_puf_ctrl_if.sv
// Handshake and data bundle between the RO PUF sequencer, the RO bank and the key/ID consumer.
// With PUF_MARGIN_EN defined the bundle also carries the per-bit instability flags.
interface ro_puf_ctrl_if #(
  parameter int N_RO   = 8,
  parameter int N_BITS = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
);
  localparam int SEL_W = $clog2(N_RO);

  logic                      i_start;
  logic [N_BITS*2*SEL_W-1:0] i_challenge;
  logic [WIN_W-1:0]          i_win;
  logic [N_RO-1:0]           i_ro_tick;
  logic                      i_ready;
  logic [N_RO-1:0]           o_ro_en;
  logic                      o_busy;
  logic                      o_valid;
  logic [N_BITS-1:0]         o_response;
  logic [CNT_W-1:0]          o_cnt_a;
  logic [CNT_W-1:0]          o_cnt_b;
  logic                      o_err;
`ifdef PUF_MARGIN_EN
  logic [N_BITS-1:0]         o_unstable;
`endif

  modport master (
    output i_start, i_challenge, i_win, i_ro_tick, i_ready,
    input  o_ro_en, o_busy, o_valid, o_response, o_cnt_a, o_cnt_b, o_err
`ifdef PUF_MARGIN_EN
    , input o_unstable
`endif
  );

  modport slave (
    input  i_start, i_challenge, i_win, i_ro_tick, i_ready,
    output o_ro_en, o_busy, o_valid, o_response, o_cnt_a, o_cnt_b, o_err
`ifdef PUF_MARGIN_EN
    , output o_unstable
`endif
  );
endinterface

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencer: measures N_BITS RO pairs over a window and packs (cntA > cntB) bits.
// Optional PUF_MARGIN_EN adds MARGIN and flags pairs whose counts differ by less than MARGIN.
//
// state   | meaning
// IDLE    | waiting for start; captures challenge and window
// LOAD    | pair enabled, counters cleared, ticks ignored (settle)
// MEASURE | window down-counter running, counting A and B ticks
// COMPARE | result bit and debug counts registered, ROs disabled
// DONE    | response valid, held until accepted
module ro_puf_ctrl #(
  parameter int N_RO   = 8,
  parameter int N_BITS = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
`ifdef PUF_MARGIN_EN
  , parameter int MARGIN = 4
`endif
) (
  input logic          clk,
  input logic          rst_n,
  ro_puf_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(N_RO);
  localparam int CH_W  = N_BITS * 2 * SEL_W;
  localparam int K_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, MEASURE, COMPARE, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   chal;
  logic [WIN_W-1:0]  win;
  logic [WIN_W-1:0]  win_cnt;
  logic [K_W-1:0]    pair;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic [N_RO-1:0]   ro_en;
  logic              busy;
  logic              valid;
  logic              err;
  logic [N_BITS-1:0] response;
  logic [CNT_W-1:0]  last_a;
  logic [CNT_W-1:0]  last_b;
  logic              req_bad;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;

  function automatic logic [SEL_W-1:0] sel_of(input logic [CH_W-1:0] ch, input int k, input int hi);
    return ch[k*2*SEL_W + hi*SEL_W +: SEL_W];
  endfunction

  function automatic logic bad_sel(input logic [SEL_W-1:0] s);
    return {1'b0, s} >= (SEL_W+1)'(N_RO);
  endfunction

  function automatic logic [N_RO-1:0] pair_en(input logic [CH_W-1:0] ch, input int k);
    logic [N_RO-1:0] en;
    en = '0;
    en[sel_of(ch, k, 0)] = 1'b1;
    en[sel_of(ch, k, 1)] = 1'b1;
    return en;
  endfunction

  always_comb begin
    req_bad = (bus.i_win == '0);
    for (int k = 0; k < N_BITS; k++) begin
      if (sel_of(bus.i_challenge, k, 0) == sel_of(bus.i_challenge, k, 1) ||
          bad_sel(sel_of(bus.i_challenge, k, 0)) || bad_sel(sel_of(bus.i_challenge, k, 1)))
        req_bad = 1'b1;
    end
  end

  assign sel_a = sel_of(chal, int'(pair), 0);
  assign sel_b = sel_of(chal, int'(pair), 1);

`ifdef PUF_MARGIN_EN
  logic [N_BITS-1:0] unstable;
  logic [CNT_W-1:0]  diff;
  assign diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
  assign bus.o_unstable = unstable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chal     <= '0;
      win      <= '0;
      win_cnt  <= '0;
      pair     <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      ro_en    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      response <= '0;
      last_a   <= '0;
      last_b   <= '0;
`ifdef PUF_MARGIN_EN
      unstable <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            chal     <= bus.i_challenge;
            win      <= bus.i_win;
            pair     <= '0;
            response <= '0;
`ifdef PUF_MARGIN_EN
            unstable <= '0;
`endif
            busy     <= 1'b1;
            err      <= req_bad;
            if (req_bad) begin
              state <= DONE;
            end else begin
              ro_en <= pair_en(bus.i_challenge, 0);
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          cnt_a   <= '0;
          cnt_b   <= '0;
          win_cnt <= win;
          state   <= MEASURE;
        end
        MEASURE: begin
          if (bus.i_ro_tick[sel_a] && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
          if (bus.i_ro_tick[sel_b] && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == WIN_W'(1)) begin
            ro_en <= '0;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          response[pair] <= (cnt_a > cnt_b);
`ifdef PUF_MARGIN_EN
          unstable[pair] <= (diff < CNT_W'(MARGIN));
`endif
          last_a <= cnt_a;
          last_b <= cnt_b;
          if (pair == K_W'(N_BITS - 1)) begin
            state <= DONE;
          end else begin
            pair  <= pair + 1'b1;
            ro_en <= pair_en(chal, int'(pair) + 1);
            state <= LOAD;
          end
        end
        DONE: begin
          // valid rises one cycle after entry, so both paths share the same handshake timing
          if (!valid) begin
            valid <= 1'b1;
          end else if (bus.i_ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ro_en    = ro_en;
  assign bus.o_busy     = busy;
  assign bus.o_valid    = valid;
  assign bus.o_err      = err;
  assign bus.o_response = response;
  assign bus.o_cnt_a    = last_a;
  assign bus.o_cnt_b    = last_b;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl: default instance plus a CNT_W=3 instance for saturation.
// Define PUF_MARGIN_EN to also check the instability flags.
module tb_ro_puf_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;
  int   cyc = 0;
  int   lat;
  logic [7:0] en_first, en_5, en_11, en_13;

  always #5 clk = ~clk;

  ro_puf_ctrl_if #(.N_RO(8), .N_BITS(4), .CNT_W(16), .WIN_W(16)) bus ();
  ro_puf_ctrl_if #(.N_RO(8), .N_BITS(2), .CNT_W(3),  .WIN_W(16)) bus2 ();

  ro_puf_ctrl #(.N_RO(8), .N_BITS(4), .CNT_W(16), .WIN_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ro_puf_ctrl #(.N_RO(8), .N_BITS(2), .CNT_W(3),  .WIN_W(16)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // mode 1: RO1/RO3 every cycle, rest every 2nd; mode 2: all every cycle
  always begin
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      1:       bus.i_ro_tick = cyc[0] ? 8'hFF : 8'h0A;
      2:       bus.i_ro_tick = 8'hFF;
      default: bus.i_ro_tick = 8'h00;
    endcase
    bus2.i_ro_tick = 8'hFB | ((cyc % 4 == 0) ? 8'h04 : 8'h00);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [23:0] chal, input logic [15:0] win, output int n_valid);
    bus.i_challenge = chal;
    bus.i_win       = win;
    bus.i_start     = 1'b1;
    step();
    bus.i_start = 1'b0;
    en_first = bus.o_ro_en;
    n_valid = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 5)  en_5  = bus.o_ro_en;
      if (n == 11) en_11 = bus.o_ro_en;
      if (n == 13) en_13 = bus.o_ro_en;
      if (bus.o_valid) begin
        n_valid = n;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check("accept_valid", bus.o_valid, 0);
    check("accept_busy", bus.o_busy, 0);
  endtask

  localparam logic [23:0] CH_MAIN = {3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};
  localparam logic [23:0] CH_TIE  = {3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd2, 3'd2};

  initial begin
    bus.i_start = 1'b0;  bus.i_challenge = '0; bus.i_win = '0; bus.i_ready = 1'b0;
    bus2.i_start = 1'b0; bus2.i_challenge = '0; bus2.i_win = '0; bus2.i_ready = 1'b1;
    repeat (3) step();
    check("rst_ro_en", bus.o_ro_en, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_response", bus.o_response, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_cnt_a", bus.o_cnt_a, 0);
`ifdef PUF_MARGIN_EN
    check("rst_unstable", bus.o_unstable, 0);
`endif
    rst_n = 1'b1;
    step();

    mode = 1;
    run(CH_MAIN, 16'd10, lat);
    check("t1_latency", lat, 49);
    check("t1_en_load", en_first, 8'h03);
    check("t1_en_measure", en_5, 8'h03);
    check("t1_en_compare", en_11, 8'h00);
    check("t1_en_pair1", en_13, 8'h0C);
    check("t1_response", bus.o_response, 4'b0011);
    check("t1_cnt_a", bus.o_cnt_a, 5);
    check("t1_cnt_b", bus.o_cnt_b, 5);
    check("t1_err", bus.o_err, 0);
    check("t1_busy", bus.o_busy, 1);
`ifdef PUF_MARGIN_EN
    check("t1_unstable", bus.o_unstable, 4'b1100);
`endif

    for (int i = 0; i < 5; i++) begin
      bus.i_start = (i == 2);
      step();
    end
    bus.i_start = 1'b0;
    check("hold_valid", bus.o_valid, 1);
    check("hold_response", bus.o_response, 4'b0011);
    check("hold_busy", bus.o_busy, 1);
    accept();
    repeat (3) step();
    check("start_ignored", bus.o_busy, 0);

    mode = 2;
    run(CH_MAIN, 16'd10, lat);
    check("t2_latency", lat, 49);
    check("t2_response", bus.o_response, 4'b0000);
    check("t2_cnt_a", bus.o_cnt_a, 10);
    check("t2_cnt_b", bus.o_cnt_b, 10);
`ifdef PUF_MARGIN_EN
    check("t2_unstable", bus.o_unstable, 4'b1111);
`endif
    accept();

    run(CH_TIE, 16'd10, lat);
    check("err_pair_latency", lat, 1);
    check("err_pair_err", bus.o_err, 1);
    check("err_pair_response", bus.o_response, 0);
    check("err_pair_en", en_first, 0);
    check("err_pair_en_done", bus.o_ro_en, 0);
    accept();

    run(CH_MAIN, 16'd0, lat);
    check("err_win_latency", lat, 1);
    check("err_win_err", bus.o_err, 1);
    check("err_win_en", en_first, 0);
    accept();

    mode = 1;
    bus.i_challenge = CH_MAIN;
    bus.i_win = 16'd10;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (5) step();
    check("mid_en_before", bus.o_ro_en, 8'h03);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", bus.o_ro_en, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_valid", bus.o_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run(CH_MAIN, 16'd10, lat);
    check("restart_latency", lat, 49);
    check("restart_response", bus.o_response, 4'b0011);
    accept();

    bus2.i_challenge = {3'd2, 3'd3, 3'd0, 3'd1};
    bus2.i_win = 16'd20;
    bus2.i_start = 1'b1;
    step();
    bus2.i_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (bus2.o_valid) begin
        lat = n;
        break;
      end
    end
    check("sat_latency", lat, 45);
    check("sat_response", bus2.o_response, 2'b10);
    check("sat_cnt_a", bus2.o_cnt_a, 7);
    check("sat_cnt_b", bus2.o_cnt_b, 5);
    check("sat_err", bus2.o_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
